// File: rtl/bus_pkg.sv
// bus_pkg: shared types and constants for the serial system-bus slave port.
// The SPLIT state exists only when SLAVE_PORT_SPLIT_EN is defined.
package bus_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 8;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        RX_ADDR,
        RX_DATA,
        MEM_WR,
        MEM_RD,
        WAIT_RD,
`ifdef SLAVE_PORT_SPLIT_EN
        SPLIT,
`endif
        TX_DATA,
        DONE
    } slave_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// serial_shift_reg: LSB-first shift register with parallel load.
// Serial data enters at the MSB and leaves at bit 0.
module serial_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic             serial_out,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] par_out
);

    logic [WIDTH-1:0] shift_q;

    // Parallel load wins over shift; reset clears the contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
        end else if (load) begin
            shift_q <= par_in;
        end else if (shift_en) begin
            shift_q <= {serial_in, shift_q[WIDTH-1:1]};
        end
    end

    assign serial_out = shift_q[0];
    assign par_out    = shift_q;

endmodule

// File: rtl/slave_port.sv
// slave_port: responder end of the serial system-bus link.
// Receives mode/address/write-data bits, performs one local memory access
// and serialises read data back. Build macro SLAVE_PORT_SPLIT_EN inserts a
// SPLIT stall of SPLIT_LAT cycles before every read access.
module slave_port
    import bus_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int READ_LAT  = 2,
    parameter int SPLIT_LAT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_bus,
    input  logic              master_valid,
    output logic              slave_ready,
    output logic              rd_bus,
    output logic              slave_valid,
    input  logic              master_ready,
    output logic              ack,
    output logic              split,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wen,
    output logic              mem_ren,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(max_int(ADDR_W, DATA_W)) + 1;
    localparam int LAT_W = $clog2(max_int(READ_LAT, SPLIT_LAT)) + 1;
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [LAT_W-1:0] READ_LAST = LAT_W'(READ_LAT - 1);
`ifdef SLAVE_PORT_SPLIT_EN
    localparam logic [LAT_W-1:0] SPLIT_LAST = LAT_W'(SPLIT_LAT - 1);
`endif

    slave_state_t      state_q, state_d;
    logic              mode_q, mode_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              slave_ready_q, slave_valid_q, ack_q;
    logic              mem_wen_q, mem_ren_q, busy_q;

    logic              wr_xfer, rd_xfer;
    logic              addr_shift, data_shift, tx_load;
    logic [ADDR_W-1:0] addr_par;
    logic [DATA_W-1:0] tx_par;
    logic              addr_so, data_so;

    assign wr_xfer = master_valid && slave_ready_q;
    assign rd_xfer = slave_valid_q && master_ready;

    serial_shift_reg #(.WIDTH(ADDR_W)) u_rx_addr (
        .clk(clk), .rst(rst), .load(1'b0), .shift_en(addr_shift),
        .serial_in(wr_bus), .serial_out(addr_so),
        .par_in('0), .par_out(addr_par)
    );

    serial_shift_reg #(.WIDTH(DATA_W)) u_rx_data (
        .clk(clk), .rst(rst), .load(1'b0), .shift_en(data_shift),
        .serial_in(wr_bus), .serial_out(data_so),
        .par_in('0), .par_out(mem_wdata)
    );

    serial_shift_reg #(.WIDTH(DATA_W)) u_tx_data (
        .clk(clk), .rst(rst), .load(tx_load), .shift_en(rd_xfer),
        .serial_in(1'b0), .serial_out(rd_bus),
        .par_in(mem_rdata), .par_out(tx_par)
    );

    logic unused_ok;
    assign unused_ok = ^{addr_so, data_so, tx_par, addr_par[0]};

    // Next-state, counter and shift-enable decode for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        bit_cnt_d  = bit_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        mem_addr_d = mem_addr_q;
        addr_shift = 1'b0;
        data_shift = 1'b0;
        tx_load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_xfer) begin
                    mode_d    = wr_bus;
                    bit_cnt_d = '0;
                    state_d   = RX_ADDR;
                end
            end
            RX_ADDR: begin
                if (wr_xfer) begin
                    addr_shift = 1'b1;
                    if (bit_cnt_q == ADDR_LAST) begin
                        bit_cnt_d  = '0;
                        // The final bit is still on wr_bus; publish the full address now.
                        mem_addr_d = {wr_bus, addr_par[ADDR_W-1:1]};
                        if (mode_q == MODE_WRITE) begin
                            state_d = RX_DATA;
                        end else begin
                            lat_cnt_d = '0;
`ifdef SLAVE_PORT_SPLIT_EN
                            state_d   = SPLIT;
`else
                            state_d   = MEM_RD;
`endif
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            RX_DATA: begin
                if (wr_xfer) begin
                    data_shift = 1'b1;
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = MEM_WR;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            MEM_WR: state_d = DONE;
`ifdef SLAVE_PORT_SPLIT_EN
            SPLIT: begin
                if (lat_cnt_q == SPLIT_LAST) begin
                    lat_cnt_d = '0;
                    state_d   = MEM_RD;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
`endif
            MEM_RD: begin
                lat_cnt_d = '0;
                state_d   = WAIT_RD;
            end
            WAIT_RD: begin
                if (lat_cnt_q == READ_LAST) begin
                    tx_load   = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = TX_DATA;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            TX_DATA: begin
                if (rd_xfer) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register plus outputs registered from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            mode_q        <= MODE_READ;
            bit_cnt_q     <= '0;
            lat_cnt_q     <= '0;
            mem_addr_q    <= '0;
            slave_ready_q <= 1'b0;
            slave_valid_q <= 1'b0;
            ack_q         <= 1'b0;
            mem_wen_q     <= 1'b0;
            mem_ren_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            bit_cnt_q     <= bit_cnt_d;
            lat_cnt_q     <= lat_cnt_d;
            mem_addr_q    <= mem_addr_d;
            slave_ready_q <= (state_d == IDLE) || (state_d == RX_ADDR) || (state_d == RX_DATA);
            slave_valid_q <= (state_d == TX_DATA);
            ack_q         <= (state_d == DONE);
            mem_wen_q     <= (state_d == MEM_WR);
            mem_ren_q     <= (state_d == MEM_RD);
            busy_q        <= (state_d != IDLE);
        end
    end

`ifdef SLAVE_PORT_SPLIT_EN
    logic split_q;

    // Split indicator mirrors residency in the SPLIT state.
    always_ff @(posedge clk) begin
        if (rst) begin
            split_q <= 1'b0;
        end else begin
            split_q <= (state_d == SPLIT);
        end
    end

    assign split = split_q;
`else
    assign split = 1'b0;
`endif

    assign slave_ready = slave_ready_q;
    assign slave_valid = slave_valid_q;
    assign ack         = ack_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wen     = mem_wen_q;
    assign mem_ren     = mem_ren_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_slave_port.sv
// tb_slave_port: scenario tasks driving serial frames into slave_port and
// checking memory strobes and returned read data against a byte-array model.
`timescale 1ns/1ps
module tb_slave_port;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 8;
    localparam int READ_LAT  = 2;
    localparam int SPLIT_LAT = 8;
`ifdef SLAVE_PORT_SPLIT_EN
    localparam int SPLIT_EXTRA = SPLIT_LAT;
`else
    localparam int SPLIT_EXTRA = 0;
`endif

    logic clk = 1'b0;
    logic rst, wr_bus, master_valid, slave_ready, rd_bus, slave_valid, master_ready;
    logic ack, split, mem_wen, mem_ren, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    slave_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT), .SPLIT_LAT(SPLIT_LAT)) dut (
        .clk(clk), .rst(rst), .wr_bus(wr_bus), .master_valid(master_valid),
        .slave_ready(slave_ready), .rd_bus(rd_bus), .slave_valid(slave_valid),
        .master_ready(master_ready), .ack(ack), .split(split), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_ren(mem_ren),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    int n_cmp = 0;
    int n_fail = 0;

    logic [DATA_W-1:0] mem     [1<<ADDR_W];  // contents of the attached device
    logic [DATA_W-1:0] ref_mem [1<<ADDR_W];  // contents predicted from frames sent

    // Event log filled by the monitor
    typedef struct { int cyc; logic mr; logic rd; } tr_t;
    tr_t trace[$];
    int cyc = 0;
    int wen_cnt, ren_cnt, ack_cnt, split_cnt, split_first, split_last, split_total = 0;
    int wen_cyc, ren_cyc, ack_cyc, first_sv_cyc, last_xfer_cyc, sv_cycles, rx_bits;
    logic [ADDR_W-1:0] wen_addr, ren_addr;
    logic [DATA_W-1:0] wen_data, rx_byte;
    logic rdy_after_ack;
    bit pend = 0;

    // Monitor and memory responder, sampled mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (cyc == ack_cyc + 1) rdy_after_ack = slave_ready && !busy;
        if (mem_wen) begin
            wen_cnt++; wen_addr = mem_addr; wen_data = mem_wdata; wen_cyc = cyc;
            mem[mem_addr] = mem_wdata;
        end
        if (mem_ren) begin
            ren_cnt++; ren_addr = mem_addr; ren_cyc = cyc; pend = 1;
        end
        if (ack) begin ack_cnt++; ack_cyc = cyc; end
        if (split) begin
            if (split_cnt == 0) split_first = cyc;
            split_cnt++; split_total++; split_last = cyc;
        end
        if (slave_valid) begin
            sv_cycles++;
            if (first_sv_cyc < 0) first_sv_cyc = cyc;
            trace.push_back('{cyc: cyc, mr: master_ready, rd: rd_bus});
            if (master_ready) begin
                if (rx_bits < DATA_W) rx_byte[rx_bits] = rd_bus;
                rx_bits++; last_xfer_cyc = cyc;
            end
        end
        if (pend && cyc == ren_cyc + READ_LAT) begin
            mem_rdata = mem[ren_addr]; pend = 0;
        end else begin
            mem_rdata = DATA_W'($urandom);
        end
    end

    task automatic clear_logs();
        wen_cnt = 0; ren_cnt = 0; ack_cnt = 0; split_cnt = 0; split_first = -1; split_last = -1;
        wen_cyc = -1; ren_cyc = -1; ack_cyc = -10; first_sv_cyc = -1; last_xfer_cyc = -1;
        sv_cycles = 0; rx_bits = 0; rx_byte = '0; rdy_after_ack = 1'b0; trace.delete();
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_bit(input logic b);
        bit ok = 0;
        logic rdy;
        master_valid = 1'b1; wr_bus = b;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); rdy = slave_ready;
            tick();
            if (rdy) begin ok = 1; break; end
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL handshake: slave_ready never 1 within 200 cycles (required 1)");
        end
    endtask

    task automatic gap(input int pct);
        if ($urandom_range(0, 99) < pct) begin
            master_valid = 1'b0; wr_bus = 1'($urandom); tick();
        end
    endtask

    // Sends one frame; lastc is the monitor cycle in which the final bit was offered
    task automatic send_frame(input logic mode, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                              input int pct, output int ncyc, output int lastc);
        int c0 = cyc;
        send_bit(mode); lastc = cyc; gap(pct);
        for (int i = 0; i < ADDR_W; i++) begin send_bit(a[i]); lastc = cyc; gap(pct); end
        if (mode) for (int i = 0; i < DATA_W; i++) begin send_bit(d[i]); lastc = cyc; gap(pct); end
        master_valid = 1'b0; wr_bus = 1'b0;
        ncyc = cyc - c0;
    endtask

    task automatic wait_done(input bit rnd_ready);
        for (int k = 0; k < 400 && ack_cnt == 0; k++) begin
            if (rnd_ready) master_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        master_ready = 1'b1;
        if (ack_cnt == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL ack_timeout: ack count %0d, required 1 within 400 cycles", ack_cnt);
        end
        tick(); tick();
    endtask

    task automatic check_holds();
        for (int i = 0; i + 1 < trace.size(); i++) begin
            if (!trace[i].mr) begin
                n_cmp++;
                if (trace[i+1].cyc !== trace[i].cyc + 1 || trace[i+1].rd !== trace[i].rd) begin
                    n_fail++;
                    $display("FAIL stall_hold: cyc %0d next valid cyc %0d rd %b, required cyc %0d rd %b",
                             trace[i].cyc, trace[i+1].cyc, trace[i+1].rd, trace[i].cyc + 1, trace[i].rd);
                end
            end
        end
    endtask

    task automatic check_write(input string nm, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        n_cmp++;
        if ({wen_cnt, ren_cnt, ack_cnt} !== {32'd1, 32'd0, 32'd1}) begin
            n_fail++;
            $display("FAIL %s_strobes: wen %0d ren %0d ack %0d, required 1 0 1", nm, wen_cnt, ren_cnt, ack_cnt);
        end
        n_cmp++;
        if (wen_addr !== a || wen_data !== d) begin
            n_fail++;
            $display("FAIL %s_wdata: %h@%h, required %h@%h", nm, wen_data, wen_addr, d, a);
        end
    endtask

    task automatic check_read(input string nm, input logic [ADDR_W-1:0] a);
        n_cmp++;
        if ({wen_cnt, ren_cnt, ack_cnt, rx_bits} !== {32'd0, 32'd1, 32'd1, 32'(DATA_W)}) begin
            n_fail++;
            $display("FAIL %s_counts: wen %0d ren %0d ack %0d bits %0d, required 0 1 1 %0d",
                     nm, wen_cnt, ren_cnt, ack_cnt, rx_bits, DATA_W);
        end
        n_cmp++;
        if (ren_addr !== a) begin
            n_fail++; $display("FAIL %s_raddr: %h, required %h", nm, ren_addr, a);
        end
        n_cmp++;
        if (rx_byte !== ref_mem[a]) begin
            n_fail++; $display("FAIL %s_rdata: %h, required %h", nm, rx_byte, ref_mem[a]);
        end
        n_cmp++;
        if (ack_cyc !== last_xfer_cyc + 1) begin
            n_fail++; $display("FAIL %s_ack_time: cyc %0d, required %0d", nm, ack_cyc, last_xfer_cyc + 1);
        end
        check_holds();
    endtask

    task automatic test_reset();
        logic [27:0] outs;
        rst = 1'b1; master_valid = 1'b0; wr_bus = 1'b0; master_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        outs = {slave_ready, rd_bus, slave_valid, ack, split, mem_wen, mem_ren, busy, mem_addr, mem_wdata};
        n_cmp++;
        if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: %h, required 0", outs); end
        tick(); rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (slave_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_early: %b, required 0", slave_ready); end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({slave_ready, busy} !== 2'b10) begin
            n_fail++; $display("FAIL reset_release: ready,busy %b, required 10", {slave_ready, busy});
        end
        tick();
    endtask

    task automatic test_write(input int pct, input int want_cyc, input string nm);
        int nc, lc;
        clear_logs();
        send_frame(1'b1, 12'hBCD, 8'hD3, pct, nc, lc);
        wait_done(0);
        ref_mem[12'hBCD] = 8'hD3;
        check_write(nm, 12'hBCD, 8'hD3);
        n_cmp++;
        if (wen_cyc !== lc + 1 || ack_cyc !== wen_cyc + 1) begin
            n_fail++;
            $display("FAIL %s_timing: wen cyc %0d ack cyc %0d, required %0d %0d", nm, wen_cyc, ack_cyc, lc + 1, lc + 2);
        end
        n_cmp++;
        if (rdy_after_ack !== 1'b1) begin
            n_fail++; $display("FAIL %s_idle_after_ack: %b, required 1", nm, rdy_after_ack);
        end
        n_cmp++;
        if (nc !== want_cyc) begin
            n_fail++; $display("FAIL %s_frame_cycles: %0d, required %0d", nm, nc, want_cyc);
        end
    endtask

    task automatic test_read();
        int nc, lc;
        mem[12'h123] = 8'h5A; ref_mem[12'h123] = 8'h5A;
        clear_logs(); master_ready = 1'b1;
        send_frame(1'b0, 12'h123, 8'h00, 0, nc, lc);
        wait_done(0);
        check_read("read", 12'h123);
        n_cmp++;
        if (ren_cyc !== lc + 1 + SPLIT_EXTRA || first_sv_cyc !== ren_cyc + 1 + READ_LAT) begin
            n_fail++;
            $display("FAIL read_latency: ren cyc %0d first valid %0d, required %0d %0d",
                     ren_cyc, first_sv_cyc, lc + 1 + SPLIT_EXTRA, lc + 2 + SPLIT_EXTRA + READ_LAT);
        end
        n_cmp++;
        if (sv_cycles !== DATA_W) begin
            n_fail++; $display("FAIL read_valid_cycles: %0d, required %0d", sv_cycles, DATA_W);
        end
    endtask

    task automatic test_read_stall();
        int nc, lc;
        logic [9:0] pat;
        pat = 10'b1111001011;  // applied LSB first: 1,1,0,1,0,0,1,1,1,1
        clear_logs(); master_ready = pat[0];
        send_frame(1'b0, 12'h123, 8'h00, 0, nc, lc);
        for (int k = 0; k < 100 && !slave_valid; k++) tick();
        for (int i = 1; i < 10; i++) begin tick(); master_ready = pat[i]; end
        tick(); master_ready = 1'b1;
        wait_done(0);
        check_read("stall", 12'h123);
        n_cmp++;
        if (sv_cycles !== DATA_W + 3) begin
            n_fail++; $display("FAIL stall_valid_cycles: %0d, required %0d", sv_cycles, DATA_W + 3);
        end
    endtask

    task automatic test_reset_abort();
        int nc, lc;
        logic [ADDR_W-1:0] a = 12'h3C5;
        clear_logs();
        send_bit(1'b1);
        for (int i = 0; i < 6; i++) send_bit(a[i]);
        master_valid = 1'b0; rst = 1'b1; tick(); tick(); rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, slave_ready, mem_addr} !== '0) begin
            n_fail++; $display("FAIL abort_state: busy %b ready %b addr %h, required 0 0 000", busy, slave_ready, mem_addr);
        end
        tick();
        send_frame(1'b1, 12'h001, 8'hFF, 0, nc, lc);
        wait_done(0);
        ref_mem[12'h001] = 8'hFF;
        check_write("abort_then_write", 12'h001, 8'hFF);
        // Reset arrives together with the final data bit: no write may follow
        clear_logs();
        a = 12'h2A2;
        send_bit(1'b1);
        for (int i = 0; i < ADDR_W; i++) send_bit(a[i]);
        for (int i = 0; i < DATA_W - 1; i++) send_bit(1'b1);
        master_valid = 1'b1; wr_bus = 1'b1; rst = 1'b1; tick();
        rst = 1'b0; master_valid = 1'b0;
        repeat (6) tick();
        n_cmp++;
        if ({wen_cnt, ack_cnt} !== {32'd0, 32'd0}) begin
            n_fail++; $display("FAIL rst_on_last_bit: wen %0d ack %0d, required 0 0", wen_cnt, ack_cnt);
        end
    endtask

    task automatic test_split();
        int nc, lc;
        clear_logs();
        send_frame(1'b0, 12'h0AA, 8'h00, 0, nc, lc);
        wait_done(0);
        check_read("split_read", 12'h0AA);
        n_cmp++;
        if (split_cnt !== SPLIT_EXTRA) begin
            n_fail++; $display("FAIL split_cycles: %0d, required %0d", split_cnt, SPLIT_EXTRA);
        end
`ifdef SLAVE_PORT_SPLIT_EN
        n_cmp++;
        if (split_first !== lc + 1 || ren_cyc !== split_last + 1) begin
            n_fail++;
            $display("FAIL split_window: first %0d last %0d ren %0d, required %0d %0d %0d",
                     split_first, split_last, ren_cyc, lc + 1, lc + SPLIT_LAT, lc + SPLIT_LAT + 1);
        end
`endif
        clear_logs();
        send_frame(1'b1, 12'h0AA, 8'h3C, 0, nc, lc);
        wait_done(0);
        ref_mem[12'h0AA] = 8'h3C;
        check_write("split_write", 12'h0AA, 8'h3C);
        n_cmp++;
        if (split_cnt !== 0) begin
            n_fail++; $display("FAIL split_on_write: %0d cycles, required 0", split_cnt);
        end
    endtask

    task automatic test_random();
        int nc, lc;
        logic mode;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [ADDR_W-1:0] pool [6];
        pool = '{12'h000, 12'hFFF, 12'h555, 12'hAAA, 12'h07E, 12'h801};
        for (int f = 0; f < 24; f++) begin
            mode = 1'($urandom);
            a = ($urandom_range(0, 1) != 0) ? pool[$urandom_range(0, 5)] : ADDR_W'($urandom);
            d = DATA_W'($urandom);
            clear_logs();
            send_frame(mode, a, d, $urandom_range(0, 50), nc, lc);
            if (mode) begin
                wait_done(0);
                ref_mem[a] = d;
                check_write("rand_write", a, d);
            end else begin
                wait_done(1);
                check_read("rand_read", a);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            mem[i] = DATA_W'($urandom); ref_mem[i] = mem[i];
        end
        test_reset();
        test_write(0, 1 + ADDR_W + DATA_W, "write");
        test_read();
        test_write(100, 2 * (1 + ADDR_W + DATA_W), "write_gaps");
        test_read_stall();
        test_reset_abort();
        test_split();
        test_random();
`ifndef SLAVE_PORT_SPLIT_EN
        n_cmp++;
        if (split_total !== 0) begin
            n_fail++; $display("FAIL split_disabled: %0d cycles high, required 0", split_total);
        end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/slave_port.md
Name: slave_port

Overview:
- Responder end of the serial system-bus link; counterpart of the master port.
- Deserialises mode, address and write-data bits from `wr_bus`.
- Performs a single-word access on a local memory interface.
- For reads, serialises the data back on `rd_bus`.
- One instance per slave device, behind the address decoder. The decoder strips the device-select bits, so only ADDR_W local bits arrive.

Parameters:
- ADDR_W, 12, local address bits received per frame.
- DATA_W, 8, data word width.
- READ_LAT, 2, cycles from `mem_ren` to `mem_rdata` valid (>=1).
- SPLIT_LAT, 8, extra stall cycles on reads before data fetch (SLAVE_PORT_SPLIT_EN only).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `wr_bus`  in  1  serial bit from master.
- `master_valid`  in  1  `wr_bus` bit valid.
- `slave_ready`  out  1  slave accepts a `wr_bus` bit.
- `rd_bus`  out  1  serial read-data bit to master.
- `slave_valid`  out  1  `rd_bus` bit valid.
- `master_ready`  in  1  master accepts an `rd_bus` bit.
- `ack`  out  1  one-cycle pulse at transaction completion.
- `split`  out  1  read split in progress (0 unless macro).
- `mem_addr`  out  ADDR_W  local memory address.
- `mem_wdata`  out  DATA_W  local write data.
- `mem_wen`  out  1  one-cycle write strobe.
- `mem_ren`  out  1  one-cycle read strobe.
- `mem_rdata`  in  DATA_W  local read data.
- `busy`  out  1  state != IDLE.

Behaviour:
- Single clock `clk`. Reset `rst` is synchronous, active-high.
- While `rst`=1: state=IDLE, counters/shift registers 0, every output 0.
  - `slave_ready` goes 1 on the first cycle after `rst` falls.
- All outputs are registered.
- Bit transfer on `wr_bus`: occurs at a rising edge with `master_valid`&&`slave_ready`.
- Bit transfer on `rd_bus`: occurs at a rising edge with `slave_valid`&&`master_ready`.
- Frame order: mode bit (1=write, 0=read), then ADDR_W address bits LSB first, then (write only) DATA_W data bits LSB first.
- FSM states: IDLE, RX_ADDR, RX_DATA, MEM_WR, MEM_RD, WAIT_RD, [SPLIT], TX_DATA, DONE.
- IDLE: `slave_ready`=1. On a transfer, latch mode, clear `bit_cnt`, go to RX_ADDR.
- RX_ADDR: `slave_ready`=1. Shift bits into addr. After bit ADDR_W-1:
  - mode=1 -> RX_DATA.
  - mode=0 -> MEM_RD (or SPLIT).
- RX_DATA: `slave_ready`=1. After DATA_W bits -> MEM_WR. `slave_ready` drops the cycle after the last bit.
- MEM_WR: `mem_wen`=1 for exactly one cycle with `mem_addr`/`mem_wdata` stable -> DONE.
- MEM_RD: `mem_ren`=1 one cycle -> WAIT_RD.
- WAIT_RD: count READ_LAT cycles, latch `mem_rdata` into tx shift register -> TX_DATA.
- TX_DATA: `slave_valid`=1, `rd_bus`=shift[0].
  - Each transfer shifts right.
  - After DATA_W transfers, `slave_valid` falls next cycle -> DONE.
  - With `master_ready`=0, `rd_bus` and `slave_valid` hold.
- DONE: `ack`=1 one cycle -> IDLE.
- `mem_addr` holds the last address until the next frame's address completes.
- `bit_cnt` width = clog2(max(ADDR_W,DATA_W))+1; it never wraps mid-field.
- Gaps in `master_valid` stall the FSM indefinitely with no timeout.
- `master_valid` outside IDLE/RX states is ignored; `slave_ready`=0 there.
- Reset mid-frame: partial frame is discarded and no memory strobe is issued. If `rst` coincides with a MEM_WR cycle, `mem_wen` is 0.

Optional Feature:
- Macro: `SLAVE_PORT_SPLIT_EN`.
- Enabled, read path:
  1. After the address completes, enter SPLIT with `split`=1 for SPLIT_LAT cycles (models a slow device releasing the bus).
  2. Then `split`=0 and go to MEM_RD.
  3. Write frames never split.
- Disabled: SPLIT state absent, `split` tied 0, read latency = 1+READ_LAT cycles to first `slave_valid`.

Decomposition:
- Package `bus_pkg`:
  - state enum `slave_state_t`.
  - mode constants `MODE_READ`=0, `MODE_WRITE`=1.
  - default ADDR_W/DATA_W constants.
- Sub-module `serial_shift_reg`:
  - parameterised width, LSB-first.
  - ports: load, shift_en, serial_in/serial_out, parallel in/out.
  - instantiated for rx address, rx data and tx data.

Test Plan:
- Write frame mode=1, addr 0xBCD, data 0xD3, `master_valid` continuous.
  - `mem_wen` one cycle with `mem_addr`=0xBCD, `mem_wdata`=0xD3.
  - `ack` pulse next cycle, then IDLE with `slave_ready`=1.
- Read frame addr 0x123, memory returns 0x5A, READ_LAT=2, `master_ready`=1.
  - `rd_bus` sequence 0,1,0,1,1,0,1,0 with `slave_valid` high 8 cycles, then `ack`.
- Write frame with `master_valid` low every other cycle.
  - Same result as the first test; total frame takes 2x cycles; no extra strobes.
- Read 0x5A with `master_ready` pattern 1,1,0,1,0,0,1,1,1,1.
  - `rd_bus` holds during stalls; bits still 0,1,0,1,1,0,1,0.
- `rst` pulsed after 6 address bits, then a clean write frame addr 0x001, data 0xFF.
  - No strobe from the aborted frame; second frame writes 0xFF@0x001.
- With `SLAVE_PORT_SPLIT_EN`, SPLIT_LAT=8, read 0x0AA.
  - `split` high exactly 8 cycles before `mem_ren`.
  - `split` stays 0 for a write frame.
